// File: rtl/instr_fetch.sv
// instr_fetch: reads the opcode byte at pc from program memory, reads the
// immediate byte at pc+1 when the decoder asks for one, and offers the
// instruction to the decoder/datapath. A flush abandons the instruction in
// flight. A memory request that has already been raised is always carried
// through to its ack; the data is discarded if a flush has intervened.
//
// Handshakes:
//   memory  : mem_req/mem_addr are held stable until mem_ack is seen high on
//             a rising edge; mem_ack may arrive in the same cycle mem_req rises.
//   consumer: the instruction transfers on a rising edge where instr_valid and
//             instr_ready are both high. instr_valid is forced low during a
//             flush cycle, so a flush always wins over a transfer. While
//             instr_valid is high and unaccepted, instr/imm/instr_pc do not move.
module instr_fetch #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    input  logic             rimm,
    input  logic             flush,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] instr_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_OP    = 3'd0,
        S_DEC   = 3'd1,
        S_IMM   = 3'd2,
        S_ISSUE = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] drain_addr;
    logic [WIDTH-1:0] imm_addr;

    // The immediate lives at the next address, wrapping at the top of memory.
    assign imm_addr  = instr_pc + WIDTH'(1);
    assign state_dbg = state;

    // Memory request decode; the request is held off while reset is asserted.
    always_comb begin
        mem_req  = 1'b0;
        mem_addr = pc;
        case (state)
            S_OP: begin
                mem_req  = rst;
                mem_addr = pc;
            end
            S_IMM: begin
                mem_req  = rst;
                mem_addr = imm_addr;
            end
            S_DRAIN: begin
                mem_req  = rst;
                mem_addr = drain_addr;
            end
            default: begin
                mem_req  = 1'b0;
                mem_addr = pc;
            end
        endcase
    end

    // Offer the instruction only when nothing is flushing it this cycle.
    always_comb begin
        instr_valid = (state == S_ISSUE) && !flush;
    end

    // Fetch sequencing: opcode, optional immediate, issue, and flush recovery.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_OP;
            instr      <= '0;
            imm        <= '0;
            instr_pc   <= '0;
            drain_addr <= '0;
        end else begin
            case (state)
                S_OP: begin
                    if (flush) begin
                        // The pending opcode read must still complete.
                        if (!mem_ack) begin
                            drain_addr <= pc;
                            state      <= S_DRAIN;
                        end else begin
                            state <= S_OP;
                        end
                    end else if (mem_ack) begin
                        instr    <= mem_rdata;
                        instr_pc <= pc;
                        state    <= S_DEC;
                    end
                end
                S_DEC: begin
                    if (flush) begin
                        state <= S_OP;
                    end else if (rimm) begin
                        state <= S_IMM;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_IMM: begin
                    if (flush) begin
                        if (!mem_ack) begin
                            drain_addr <= imm_addr;
                            state      <= S_DRAIN;
                        end else begin
                            state <= S_OP;
                        end
                    end else if (mem_ack) begin
                        imm   <= mem_rdata;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (flush) begin
                        state <= S_OP;
                    end else if (instr_ready) begin
                        state <= S_OP;
                    end
                end
                S_DRAIN: begin
                    // Read data returned here belongs to an abandoned fetch.
                    if (mem_ack) begin
                        state <= S_OP;
                    end
                end
                default: begin
                    state <= S_OP;
                end
            endcase
        end
    end

endmodule
